panda_risc_v_ibus_ctrler: RTL and testbench

//  Instruction bus control unit between the IMEM access controller and the instruction memory bus (ICB-style cmd/rsp).

---
 rtl/panda_risc_v_pkg.sv | 27 ++
 rtl/panda_risc_v_ibus_trans_tracker.sv | 124 ++++++++++++
 rtl/panda_risc_v_ibus_ctrler.sv | 102 ++++++++++
 tb/tb_panda_risc_v_ibus_ctrler.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/panda_risc_v_pkg.sv
`default_nettype none
// ============================================================================
// Module      : panda_risc_v_pkg
// Description : Shared constants for the instruction fetch path. The IMEM
//               access controller and the ibus controller both decode the
//               same error codes and use the same NOP filler instruction.
// Revision    : 1.0 - initial release
// ============================================================================
package panda_risc_v_pkg;

    // Error code returned alongside every IMEM access response
    localparam logic [1:0] IMEM_ACCESS_NORMAL       = 2'b00;
    localparam logic [1:0] IMEM_ACCESS_PC_UNALIGNED = 2'b01;
    localparam logic [1:0] IMEM_ACCESS_BUS_ERR      = 2'b10;
    localparam logic [1:0] IMEM_ACCESS_TIMEOUT      = 2'b11;

    // addi x0, x0, 0 - handed back whenever the fetch failed
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // What a tracking-queue entry stands for
    typedef enum logic {
        KIND_BUS        = 1'b0,
        KIND_MISALIGNED = 1'b1
    } trans_kind_t;

endpackage
`default_nettype wire

// File: rtl/panda_risc_v_ibus_trans_tracker.sv
`default_nettype none
// ============================================================================
// Module      : panda_risc_v_ibus_trans_tracker
// Description : In-order tracking of outstanding fetches: 4-deep kind FIFO,
//               head-of-queue timeout counter and orphan-response counter.
//               Decides when the head retires and with which error code.
// Revision    : 1.0 - initial release
// ============================================================================
module panda_risc_v_ibus_trans_tracker
    import panda_risc_v_pkg::*;
#(
    parameter int IMEM_ACCESS_TIMEOUT_TH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  trans_kind_t i_push_kind,
    input  logic        i_rsp_valid,
    input  logic        i_rsp_err,
    output logic        o_full,
    output logic        o_pop,
    output logic        o_rsp_take,
    output logic [1:0]  o_err_code
);

    localparam int          c_DEPTH   = 4;
    localparam logic        c_TO_EN   = (IMEM_ACCESS_TIMEOUT_TH != 0);
    localparam logic [31:0] c_TO_LAST = 32'(IMEM_ACCESS_TIMEOUT_TH - 1);

    trans_kind_t r_kind [c_DEPTH];
    logic [1:0]  r_wptr;
    logic [1:0]  r_rptr;
    logic [2:0]  r_count;
    logic [31:0] r_to_cnt;
    logic [2:0]  r_orphan_cnt;

    logic        w_empty;
    trans_kind_t w_head_kind;
    logic        w_mis_pop;
    logic        w_rsp_take;
    logic        w_rsp_drop;
    logic        w_timeout;
    logic        w_pop;

    assign w_empty     = (r_count == 3'd0);
    assign w_head_kind = r_kind[r_rptr];
    assign o_full      = (r_count == 3'(c_DEPTH));

    // Head retirement: misaligned entries retire at once, bus entries on
    // their response or on timeout; a response beats a same-cycle timeout.
    always_comb begin
        w_mis_pop  = !w_empty && (w_head_kind == KIND_MISALIGNED);
        w_rsp_take = i_rsp_valid && (r_orphan_cnt == 3'd0) && !w_empty &&
                     (w_head_kind == KIND_BUS);
        w_rsp_drop = i_rsp_valid && (r_orphan_cnt != 3'd0);
        w_timeout  = c_TO_EN && !w_empty && (w_head_kind == KIND_BUS) &&
                     !w_rsp_take && (r_to_cnt == c_TO_LAST);
        w_pop      = w_mis_pop || w_rsp_take || w_timeout;

        o_err_code = IMEM_ACCESS_NORMAL;
        if (w_mis_pop)
            o_err_code = IMEM_ACCESS_PC_UNALIGNED;
        else if (w_timeout)
            o_err_code = IMEM_ACCESS_TIMEOUT;
        else if (i_rsp_err)
            o_err_code = IMEM_ACCESS_BUS_ERR;
    end

    assign o_pop      = w_pop;
    assign o_rsp_take = w_rsp_take;

    // Kind FIFO with wrapping pointers and occupancy count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++)
                r_kind[i] <= KIND_BUS;
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (i_push) begin
                r_kind[r_wptr] <= i_push_kind;
                r_wptr         <= r_wptr + 2'd1;
            end
            if (w_pop)
                r_rptr <= r_rptr + 2'd1;
            r_count <= r_count + {2'b00, i_push} - {2'b00, w_pop};
        end
    end

    // Cycles the current bus head has been waiting for its response
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_to_cnt <= 32'd0;
        else if (!c_TO_EN || w_pop || w_empty || (w_head_kind == KIND_MISALIGNED))
            r_to_cnt <= 32'd0;
        else
            r_to_cnt <= r_to_cnt + 32'd1;
    end

    // Bus responses still owed for timed-out entries; they get discarded
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_orphan_cnt <= 3'd0;
        else if (w_timeout && !w_rsp_drop)
            r_orphan_cnt <= r_orphan_cnt + 3'd1;
        else if (!w_timeout && w_rsp_drop)
            r_orphan_cnt <= r_orphan_cnt - 3'd1;
    end

    a_one_pop: assert property (@(posedge clk) disable iff (rst)
        $onehot0({w_mis_pop, w_rsp_take, w_timeout}));

    a_no_stray_rsp: assert property (@(posedge clk) disable iff (rst)
        i_rsp_valid |-> (!w_empty || (r_orphan_cnt != 3'd0)));

    // A consumed response must meet a bus entry at the head, otherwise it
    // would be lost behind a misaligned entry.
    a_rsp_meets_bus_head: assert property (@(posedge clk) disable iff (rst)
        i_rsp_valid |-> ((r_orphan_cnt != 3'd0) ||
                         (!w_empty && (w_head_kind == KIND_BUS))));

endmodule
`default_nettype wire

// File: rtl/panda_risc_v_ibus_ctrler.sv
`default_nettype none
// ============================================================================
// Module      : panda_risc_v_ibus_ctrler
// Description : Instruction bus controller between the IMEM access port and
//               an ICB-style cmd/rsp bus. Flags misaligned PCs locally, keeps
//               up to 4 fetches in flight and returns registered responses in
//               request order with a 2-bit error code.
// Revision    : 1.0 - initial release
// ============================================================================
module panda_risc_v_ibus_ctrler
    import panda_risc_v_pkg::*;
#(
    parameter int IMEM_ACCESS_TIMEOUT_TH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_access_req_addr,
    input  logic        imem_access_req_read,
    input  logic [31:0] imem_access_req_wdata,
    input  logic [3:0]  imem_access_req_wmask,
    input  logic        imem_access_req_valid,
    output logic        imem_access_req_ready,
    output logic [31:0] imem_access_resp_rdata,
    output logic [1:0]  imem_access_resp_err,
    output logic        imem_access_resp_valid,
    output logic [31:0] ibus_cmd_addr,
    output logic        ibus_cmd_read,
    output logic [31:0] ibus_cmd_wdata,
    output logic [3:0]  ibus_cmd_wmask,
    output logic        ibus_cmd_valid,
    input  logic        ibus_cmd_ready,
    input  logic [31:0] ibus_rsp_rdata,
    input  logic        ibus_rsp_err,
    input  logic        ibus_rsp_valid,
    output logic        ibus_rsp_ready
);

    logic        w_misaligned;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic        w_rsp_take;
    logic [1:0]  w_err_code;
    logic        w_unused;

    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic [1:0]  r_resp_err;

    // Fetch is read-only, so the write side of the request is never used
    assign w_unused = ^{imem_access_req_read, imem_access_req_wdata, imem_access_req_wmask};

    assign w_misaligned = (imem_access_req_addr[1:0] != 2'b00);

    // Misaligned requests bypass the bus; aligned ones need the bus to take
    // the command. Nothing is accepted while the tracker is full or in reset.
    assign ibus_cmd_valid        = !rst && imem_access_req_valid && !w_full && !w_misaligned;
    assign imem_access_req_ready = !rst && !w_full && (w_misaligned || ibus_cmd_ready);
    assign w_push                = imem_access_req_valid && imem_access_req_ready;

    assign ibus_cmd_addr  = imem_access_req_addr;
    assign ibus_cmd_read  = 1'b1;
    assign ibus_cmd_wdata = 32'h0000_0000;
    assign ibus_cmd_wmask = 4'b0000;
    assign ibus_rsp_ready = 1'b1;

    panda_risc_v_ibus_trans_tracker #(
        .IMEM_ACCESS_TIMEOUT_TH(IMEM_ACCESS_TIMEOUT_TH)
    ) u_tracker (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_kind (w_misaligned ? KIND_MISALIGNED : KIND_BUS),
        .i_rsp_valid (ibus_rsp_valid),
        .i_rsp_err   (ibus_rsp_err),
        .o_full      (w_full),
        .o_pop       (w_pop),
        .o_rsp_take  (w_rsp_take),
        .o_err_code  (w_err_code)
    );

    // Response register: one pulse per retired entry, NOP on any error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= NOP_INST;
            r_resp_err   <= IMEM_ACCESS_NORMAL;
        end else begin
            r_resp_valid <= w_pop;
            if (w_pop) begin
                r_resp_err   <= w_err_code;
                r_resp_rdata <= (w_rsp_take && !ibus_rsp_err) ? ibus_rsp_rdata : NOP_INST;
            end
        end
    end

    assign imem_access_resp_valid = r_resp_valid;
    assign imem_access_resp_rdata = r_resp_rdata;
    assign imem_access_resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_panda_risc_v_ibus_ctrler.sv
`default_nettype none
// ============================================================================
// Module      : tb_panda_risc_v_ibus_ctrler
// Description : Scoreboard bench for the ibus controller. Requests push their
//               expected response; a bus model answers in order with a
//               planned latency; monitors pop and compare each response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_panda_risc_v_ibus_ctrler;

    localparam logic [31:0] c_NOP = 32'h0000_0013;
    localparam int          c_TH  = 32;

    typedef struct { logic [31:0] rdata; logic [1:0] err; int cyc; } exp_t;
    typedef struct { logic [31:0] addr; logic [31:0] rdata; logic err; int lat; } plan_t;
    typedef struct { logic [31:0] rdata; logic err; int due; } pend_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    // DUT A (timeout 32)
    logic [31:0] req_addr, resp_rdata, cmd_addr, cmd_wdata, rsp_rdata;
    logic [3:0]  cmd_wmask;
    logic [1:0]  resp_err;
    logic        req_valid, req_ready, resp_valid, cmd_read, cmd_valid, cmd_ready;
    logic        rsp_err, rsp_valid, rsp_ready;
    // DUT B (timeout disabled)
    logic [31:0] b_req_addr, b_resp_rdata, b_cmd_addr, b_cmd_wdata, b_rsp_rdata;
    logic [3:0]  b_cmd_wmask;
    logic [1:0]  b_resp_err;
    logic        b_req_valid, b_req_ready, b_resp_valid, b_cmd_read, b_cmd_valid, b_cmd_ready;
    logic        b_rsp_err, b_rsp_valid, b_rsp_ready;

    exp_t  exp_q[$];
    exp_t  exp_b_q[$];
    plan_t plan_q[$];
    pend_t pend_q[$];
    int    last_due = -100;
    logic  cmd_rdy_rand = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    panda_risc_v_ibus_ctrler #(.IMEM_ACCESS_TIMEOUT_TH(c_TH)) dut (
        .clk(clk), .rst(rst),
        .imem_access_req_addr(req_addr), .imem_access_req_read(1'b1),
        .imem_access_req_wdata(32'h0), .imem_access_req_wmask(4'h0),
        .imem_access_req_valid(req_valid), .imem_access_req_ready(req_ready),
        .imem_access_resp_rdata(resp_rdata), .imem_access_resp_err(resp_err),
        .imem_access_resp_valid(resp_valid),
        .ibus_cmd_addr(cmd_addr), .ibus_cmd_read(cmd_read), .ibus_cmd_wdata(cmd_wdata),
        .ibus_cmd_wmask(cmd_wmask), .ibus_cmd_valid(cmd_valid), .ibus_cmd_ready(cmd_ready),
        .ibus_rsp_rdata(rsp_rdata), .ibus_rsp_err(rsp_err), .ibus_rsp_valid(rsp_valid),
        .ibus_rsp_ready(rsp_ready)
    );

    panda_risc_v_ibus_ctrler #(.IMEM_ACCESS_TIMEOUT_TH(0)) dut_nt (
        .clk(clk), .rst(rst),
        .imem_access_req_addr(b_req_addr), .imem_access_req_read(1'b1),
        .imem_access_req_wdata(32'h0), .imem_access_req_wmask(4'h0),
        .imem_access_req_valid(b_req_valid), .imem_access_req_ready(b_req_ready),
        .imem_access_resp_rdata(b_resp_rdata), .imem_access_resp_err(b_resp_err),
        .imem_access_resp_valid(b_resp_valid),
        .ibus_cmd_addr(b_cmd_addr), .ibus_cmd_read(b_cmd_read), .ibus_cmd_wdata(b_cmd_wdata),
        .ibus_cmd_wmask(b_cmd_wmask), .ibus_cmd_valid(b_cmd_valid), .ibus_cmd_ready(b_cmd_ready),
        .ibus_rsp_rdata(b_rsp_rdata), .ibus_rsp_err(b_rsp_err), .ibus_rsp_valid(b_rsp_valid),
        .ibus_rsp_ready(b_rsp_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor A: every response pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got rdata 0x%0h err %b, expected no response",
                         resp_rdata, resp_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", 64'(resp_err), 64'(e.err));
                if (e.cyc >= 0)
                    check("resp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (!rst && b_resp_valid) begin
            if (exp_b_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL nt_unexpected_resp: got rdata 0x%0h err %b, expected no response",
                         b_resp_rdata, b_resp_err);
            end else begin
                exp_t e;
                e = exp_b_q.pop_front();
                check("nt_resp_rdata", b_resp_rdata, e.rdata);
                check("nt_resp_err", 64'(b_resp_err), 64'(e.err));
            end
        end
    end

    // Bus model for A: in-order responses, planned latency, >=4 cycles apart
    always begin
        @(negedge clk);
        if (rst) begin
            pend_q.delete();
            last_due = -100;
        end else if (cmd_valid && cmd_ready) begin
            if (plan_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL cmd_unplanned: got cmd addr 0x%0h, expected no command", cmd_addr);
            end else begin
                plan_t p;
                pend_t q;
                p = plan_q.pop_front();
                check("cmd_addr", cmd_addr, p.addr);
                q.rdata = p.rdata;
                q.err   = p.err;
                q.due   = cyc + 1 + p.lat;
                if (q.due < last_due + 4)
                    q.due = last_due + 4;
                last_due = q.due;
                pend_q.push_back(q);
            end
        end
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = $urandom;
        if (!rst && pend_q.size() > 0 && pend_q[0].due == cyc) begin
            pend_t q;
            q = pend_q.pop_front();
            rsp_valid = 1'b1;
            rsp_rdata = q.rdata;
            rsp_err   = q.err;
        end
        cmd_ready = cmd_rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Issue one request and push the response the specification predicts
    task automatic send(input logic [31:0] addr, input logic [31:0] data, input logic berr,
                        input int lat, input logic to, input logic timed, input logic chk_block,
                        output int acc);
        exp_t  e;
        plan_t p;
        int    waited;
        waited = 0;
        acc    = -1;
        @(posedge clk);
        #1;
        if (addr[1:0] == 2'b00) begin
            p.addr = addr; p.rdata = data; p.err = berr; p.lat = lat;
            plan_q.push_back(p);
        end
        req_addr  = addr;
        req_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (chk_block && waited == 0) begin
                check("full_req_ready", 64'(req_ready), 64'(0));
                check("full_cmd_valid", 64'(cmd_valid), 64'(0));
            end
            if (req_ready) begin
                acc = cyc;
                break;
            end
            waited++;
            if (waited > 300) begin
                n_checks++;
                n_fail++;
                $display("FAIL req_accept: got no req_ready in 300 cycles, expected acceptance");
                break;
            end
            @(posedge clk);
            #1;
        end
        if (acc >= 0) begin
            e.cyc = -1;
            if (addr[1:0] != 2'b00) begin
                check("mis_no_cmd", 64'(cmd_valid), 64'(0));
                e.rdata = c_NOP; e.err = 2'b01;
                if (timed) e.cyc = acc + 2;
            end else if (to) begin
                e.rdata = c_NOP; e.err = 2'b11;
                if (timed) e.cyc = acc + 1 + c_TH;
            end else begin
                e.rdata = berr ? c_NOP : data;
                e.err   = berr ? 2'b10 : 2'b00;
                if (timed) e.cyc = acc + 2 + lat;
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int j, j0, j5;
        logic [31:0] a;
        rst = 1'b1;
        req_valid = 1'b0; req_addr = 32'h0;
        b_req_valid = 1'b0; b_req_addr = 32'h0; b_cmd_ready = 1'b0;
        b_rsp_valid = 1'b0; b_rsp_err = 1'b0; b_rsp_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state with a pending aligned request that must stay blocked
        req_addr = 32'h100; req_valid = 1'b1;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_cmd_valid", 64'(cmd_valid), 64'(0));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_resp_rdata", resp_rdata, c_NOP);
        check("rst_resp_err", 64'(resp_err), 64'(0));
        check("const_cmd_read", 64'(cmd_read), 64'(1));
        check("const_cmd_wdata", cmd_wdata, 64'(0));
        check("const_cmd_wmask", 64'(cmd_wmask), 64'(0));
        check("const_rsp_ready", 64'(rsp_ready), 64'(1));
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single aligned fetch, response two cycles after the command
        send(32'h100, 32'h00A0_0093, 1'b0, 2, 1'b0, 1'b1, 1'b0, j);
        drain("t1");

        // Misaligned fetch, then interleaved ok / misaligned / ok
        send(32'h102, 32'h0, 1'b0, 1, 1'b0, 1'b1, 1'b0, j);
        drain("t2a");
        send(32'h100, 32'h1111_0001, 1'b0, 6, 1'b0, 1'b0, 1'b0, j);
        send(32'h102, 32'h0, 1'b0, 1, 1'b0, 1'b0, 1'b0, j);
        send(32'h104, 32'h2222_0002, 1'b0, 1, 1'b0, 1'b0, 1'b0, j);
        drain("t2b");

        // Fill the queue; the fifth request waits for the first response
        send(32'h400, 32'h4000_0000, 1'b0, 12, 1'b0, 1'b0, 1'b0, j0);
        send(32'h404, 32'h4000_0004, 1'b0, 1, 1'b0, 1'b0, 1'b0, j);
        send(32'h408, 32'h4000_0008, 1'b0, 1, 1'b0, 1'b0, 1'b0, j);
        send(32'h40C, 32'h4000_000C, 1'b0, 1, 1'b0, 1'b0, 1'b0, j);
        send(32'h410, 32'h4000_0010, 1'b0, 1, 1'b0, 1'b0, 1'b1, j5);
        check("full_release_cycle", 64'(j5), 64'(j0 + 14));
        drain("t3");

        // Timeout after 32 cycles; late response dropped; next one normal
        send(32'h300, 32'h3333_3333, 1'b0, 40, 1'b1, 1'b1, 1'b0, j);
        drain("t4a");
        send(32'h304, 32'h3030_3030, 1'b0, 1, 1'b0, 1'b0, 1'b0, j);
        drain("t4b");
        repeat (10) @(posedge clk);

        // Bus error replaces data with NOP
        send(32'h500, 32'hDEAD_BEEF, 1'b1, 3, 1'b0, 1'b1, 1'b0, j);
        drain("t5");

        // Randomized mix with random cmd_ready
        cmd_rdy_rand = 1'b1;
        for (int i = 0; i < 80; i++) begin
            a = $urandom;
            a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            send(a, $urandom, ($urandom_range(0, 7) == 0), $urandom_range(1, 10),
                 1'b0, 1'b0, 1'b0, j);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain("rand");
        cmd_rdy_rand = 1'b0;
        repeat (3) @(posedge clk);

        // Reset with three fetches outstanding
        send(32'h600, 32'h6000_0000, 1'b0, 30, 1'b0, 1'b0, 1'b0, j);
        send(32'h604, 32'h6000_0004, 1'b0, 30, 1'b0, 1'b0, 1'b0, j);
        send(32'h608, 32'h6000_0008, 1'b0, 30, 1'b0, 1'b0, 1'b0, j);
        @(posedge clk);
        #1;
        req_addr = 32'h60C; req_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_req_ready", 64'(req_ready), 64'(0));
        check("mid_rst_cmd_valid", 64'(cmd_valid), 64'(0));
        check("mid_rst_resp_valid", 64'(resp_valid), 64'(0));
        check("mid_rst_resp_rdata", resp_rdata, c_NOP);
        check("mid_rst_resp_err", 64'(resp_err), 64'(0));
        req_valid = 1'b0;
        exp_q.delete();
        plan_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send(32'h200, 32'h0020_0213, 1'b0, 2, 1'b0, 1'b1, 1'b0, j);
        drain("t6");
        repeat (40) @(posedge clk);

        // Timeout disabled: a response 100 cycles late is still delivered
        @(posedge clk);
        #1;
        b_req_addr = 32'h700; b_req_valid = 1'b1; b_cmd_ready = 1'b1;
        j = 0;
        @(negedge clk);
        while (!b_req_ready && j < 20) begin
            @(negedge clk);
            j++;
        end
        check("nt_req_ready", 64'(b_req_ready), 64'(1));
        check("nt_cmd_valid", 64'(b_cmd_valid), 64'(1));
        exp_b_q.push_back('{rdata: 32'h7777_0013, err: 2'b00, cyc: -1});
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        b_rsp_valid = 1'b1; b_rsp_rdata = 32'h7777_0013;
        @(posedge clk);
        #1;
        b_rsp_valid = 1'b0;
        j = 0;
        while (exp_b_q.size() != 0 && j < 10) begin
            @(negedge clk);
            j++;
        end
        check("nt_drained", 64'(exp_b_q.size()), 64'(0));

        repeat (5) @(posedge clk);
        check("final_scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
